// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and sequencer for a single-port word memory.
// It runs one transaction at a time: arbitrate, drive the memory for one cycle, wait out the read latency, then respond.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_err_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_err_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;     // 1: m1 owns the transaction
    logic          last_q, last_d;   // 1: m1 was granted most recently
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          m1_wins;
    logic [AW-1:0] addr_sel;
    logic          gnt, rvalid;

    assign m1_wins  = m1_req_i && (!m0_req_i || !last_q);
    assign addr_sel = m1_wins ? m1_addr_i : m0_addr_i;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        we_d        = we_q;
        oor_d       = oor_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    win_d   = m1_wins;
                    last_d  = m1_wins;
                    we_d    = m1_wins ? m1_we_i : m0_we_i;
                    addr_d  = addr_sel;
                    wdata_d = m1_wins ? m1_wdata_i : m0_wdata_i;
                    oor_d   = ({1'b0, addr_sel} >= DEPTH_W);
                    rdata_d = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                gnt         = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_we_o    = we_q && !oor_q;
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = oor_q ? '0 : mem_rdata_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                rvalid  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m0_gnt_o    = gnt && !win_q;
    assign m1_gnt_o    = gnt && win_q;
    assign m0_rvalid_o = rvalid && !win_q;
    assign m1_rvalid_o = rvalid && win_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
    assign m0_err_o    = m0_rvalid_o && oor_q;
    assign m1_err_o    = m1_rvalid_o && oor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
